// File: rtl/mysystem_pio_pkg.sv
// Shared types and defaults for the PIO master: FSM state encoding, bus widths,
// read latency and wait-timeout defaults, and the width of the wait counter.
package mysystem_pio_pkg;

  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RD_LAT  = 0;
  localparam int DEF_TIMEOUT = 255;
  localparam int WAIT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } pio_state_t;

endpackage

// File: rtl/mysystem_wait_timer.sv
// Waitrequest timer: counts stalled bus cycles and flags the cycle whose
// increment brings the count up to LIMIT.
module mysystem_wait_timer
  import mysystem_pio_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WAIT_W'(1);
    end
  end

  // Expiry is raised during the stalled cycle itself so the bus is released
  // after exactly LIMIT stalled cycles.
  assign expired = enable && (count == WAIT_W'(LIMIT - 1));

endmodule

// File: rtl/mysystem_pio_master.sv
// Single-outstanding PIO master: turns a command handshake into one Avalon-style
// read or write access and returns the result on a response handshake.
module mysystem_pio_master
  import mysystem_pio_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = DEF_RD_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  pio_state_t state;
  logic       expired;

  assign cmd_ready = (state == ST_IDLE);

  mysystem_wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (cmd_ready && cmd_valid),
    .enable ((state == ST_ACCESS) && avm_waitrequest),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_error      <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            avm_address    <= cmd_address;
            avm_writedata  <= cmd_wdata;
            avm_chipselect <= 1'b1;
            avm_write_n    <= ~cmd_write;
            avm_read_n     <= cmd_write;
            state          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!avm_waitrequest || expired) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            // The strobe registers still hold the operation type here.
            if (avm_waitrequest) begin
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else if (!avm_write_n) begin
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else if (RD_LAT == 0) begin
              rsp_rdata <= avm_readdata;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          rsp_rdata <= avm_readdata;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mysystem_pio_master.sv
// Bench for mysystem_pio_master: two instances (read latency 0 and 1, timeout 8)
// against a bus slave and a transaction-level reference model.
module tb_mysystem_pio_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_write [2];
  logic [1:0]  cmd_address [2];
  logic [31:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_error [2];
  logic [1:0]  avm_address [2];
  logic        avm_chipselect [2];
  logic        avm_write_n [2];
  logic        avm_read_n [2];
  logic [31:0] avm_writedata [2];
  logic [31:0] avm_readdata [2];
  logic        avm_waitrequest [2];

  logic [31:0] smem [2][4];
  logic [31:0] emem [2][4];
  logic [31:0] rq1;
  int          wcnt [2];
  int          wait_req [2];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mysystem_pio_master #(.ADDR_W(2), .DATA_W(32), .RD_LAT(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_address(cmd_address[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0]), .avm_address(avm_address[0]),
    .avm_chipselect(avm_chipselect[0]), .avm_write_n(avm_write_n[0]),
    .avm_read_n(avm_read_n[0]), .avm_writedata(avm_writedata[0]),
    .avm_readdata(avm_readdata[0]), .avm_waitrequest(avm_waitrequest[0])
  );

  mysystem_pio_master #(.ADDR_W(2), .DATA_W(32), .RD_LAT(1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_address(cmd_address[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1]), .avm_address(avm_address[1]),
    .avm_chipselect(avm_chipselect[1]), .avm_write_n(avm_write_n[1]),
    .avm_read_n(avm_read_n[1]), .avm_writedata(avm_writedata[1]),
    .avm_readdata(avm_readdata[1]), .avm_waitrequest(avm_waitrequest[1])
  );

  // Slave: stalls for wait_req cycles per access; junk on readdata outside the valid cycle.
  assign avm_waitrequest[0] = avm_chipselect[0] && (wcnt[0] < wait_req[0]);
  assign avm_waitrequest[1] = avm_chipselect[1] && (wcnt[1] < wait_req[1]);
  assign avm_readdata[0] = (avm_chipselect[0] && !avm_read_n[0]) ?
                           smem[0][avm_address[0]] : 32'hDEAD_BEEF;
  assign avm_readdata[1] = rq1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int a = 0; a < 4; a++) smem[d][a] <= '0;
      end else if (avm_chipselect[d] && !avm_write_n[d] && !avm_waitrequest[d]) begin
        smem[d][avm_address[d]] <= avm_writedata[d];
      end
      wcnt[d] <= avm_chipselect[d] ? wcnt[d] + 1 : 0;
    end
    rq1 <= (avm_chipselect[1] && !avm_read_n[1] && !avm_waitrequest[1]) ?
           smem[1][avm_address[1]] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 4; a++) emem[d][a] = '0;
  endtask

  task automatic check_idle_bus(input int d, input string tag);
    chk({tag, "_cs"}, 32'(avm_chipselect[d]), 32'd0);
    chk({tag, "_wn"}, 32'(avm_write_n[d]), 32'd1);
    chk({tag, "_rn"}, 32'(avm_read_n[d]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  // Runs one transaction; entered and left on a falling edge.
  task automatic txn(input int d, input bit wr, input logic [1:0] a, input logic [31:0] wd,
                     input int waits, input int rdly, input string tag);
    logic [31:0] exp_rdata, held;
    bit exp_err, got, bus_ok, hold_ok;
    int exp_cs, exp_lat, cyc, cs_cyc;
    exp_err = (waits >= TMO);
    exp_cs = exp_err ? TMO : waits + 1;
    exp_lat = exp_cs + 1 + ((!wr && !exp_err && d == 1) ? 1 : 0);
    exp_rdata = '0;
    if (!exp_err) begin
      if (wr) emem[d][a] = wd;
      else exp_rdata = emem[d][a];
    end
    chk({tag, "_cmd_ready"}, 32'(cmd_ready[d]), 32'd1);
    wait_req[d] = waits;
    cmd_valid[d] = 1'b1; cmd_write[d] = wr; cmd_address[d] = a; cmd_wdata[d] = wd;
    rsp_ready[d] = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    cyc = 0; cs_cyc = 0; bus_ok = 1'b1; got = 1'b0;
    while (!got && cyc < 200) begin
      // Busy period: junk commands and stray rsp_ready must have no effect.
      cmd_valid[d] = 1'($urandom_range(0, 1));
      cmd_write[d] = 1'($urandom_range(0, 1));
      cmd_address[d] = 2'($urandom_range(0, 3));
      cmd_wdata[d] = $urandom;
      @(negedge clk);
      cyc++;
      if (rsp_valid[d]) begin
        got = 1'b1;
      end else begin
        if (avm_chipselect[d]) begin
          cs_cyc++;
          if (avm_address[d] != a || avm_write_n[d] != !wr || avm_read_n[d] != wr ||
              (wr && avm_writedata[d] != wd)) bus_ok = 1'b0;
        end else if (!(avm_write_n[d] && avm_read_n[d])) begin
          bus_ok = 1'b0;
        end
        if (cmd_ready[d]) bus_ok = 1'b0;
        rsp_ready[d] = 1'($urandom_range(0, 1));
      end
    end
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_access_cycles"}, 32'(cs_cyc), 32'(exp_cs));
    chk({tag, "_bus_protocol"}, 32'(bus_ok), 32'd1);
    chk({tag, "_rdata"}, rsp_rdata[d], exp_rdata);
    chk({tag, "_error"}, 32'(rsp_error[d]), 32'(exp_err));
    held = rsp_rdata[d];
    hold_ok = 1'b1;
    rsp_ready[d] = 1'b0;
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      if (!rsp_valid[d] || rsp_rdata[d] != held || rsp_error[d] != exp_err ||
          cmd_ready[d] || avm_chipselect[d]) hold_ok = 1'b0;
    end
    chk({tag, "_resp_hold"}, 32'(hold_ok), 32'd1);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    chk({tag, "_rsp_done"}, 32'({rsp_valid[d], rsp_error[d]}), 32'd0);
    chk({tag, "_ready_again"}, 32'(cmd_ready[d]), 32'd1);
    rsp_ready[d] = 1'b0;
    cmd_valid[d] = 1'b0;
  endtask

  initial begin
    bit quiet;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0; cmd_address[d] = '0; cmd_wdata[d] = '0;
      rsp_ready[d] = 1'b0; wait_req[d] = 0;
    end
    clear_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_idle_bus(d, "reset");
      chk("reset_rsp_error", 32'(rsp_error[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset_address", 32'(avm_address[d]), 32'd0);
      chk("reset_writedata", avm_writedata[d], 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("first_edge_ready0", 32'(cmd_ready[0]), 32'd1);
    chk("first_edge_ready1", 32'(cmd_ready[1]), 32'd1);
    @(negedge clk);

    txn(0, 1'b1, 2'd0, 32'h0000_0001, 0, 0, "zw_write");
    txn(0, 1'b0, 2'd0, 32'h0, 0, 0, "zw_read_lat0");
    txn(1, 1'b1, 2'd1, 32'hA5A5_A5A5, 0, 1, "write_lat1");
    txn(1, 1'b0, 2'd1, 32'h0, 0, 0, "read_lat1");
    txn(0, 1'b1, 2'd2, 32'h1234_5678, 3, 2, "wait3_write");
    txn(0, 1'b0, 2'd2, 32'h0, 3, 0, "wait3_read");
    txn(0, 1'b1, 2'd3, 32'hCAFE_F00D, 100, 0, "timeout_write");
    txn(0, 1'b0, 2'd3, 32'h0, 100, 1, "timeout_read");
    txn(1, 1'b0, 2'd1, 32'h0, 100, 0, "timeout_read_lat1");
    txn(0, 1'b1, 2'd3, 32'h0BAD_CAFE, 7, 0, "wait7_write");

    // Reset in the middle of a stalled access.
    wait_req[0] = 100;
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_address[0] = 2'd2; cmd_wdata[0] = 32'h7777_7777;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_cs", 32'(avm_chipselect[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_idle_bus(0, "mid_reset");
    chk("mid_reset_ready", 32'(cmd_ready[0]), 32'd1);
    chk("mid_reset_address", 32'(avm_address[0]), 32'd0);
    chk("mid_reset_writedata", avm_writedata[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid[0] || avm_chipselect[0] || !cmd_ready[0]) quiet = 1'b0;
    end
    chk("no_rsp_after_reset", 32'(quiet), 32'd1);
    txn(0, 1'b0, 2'd2, 32'h0, 0, 4, "post_reset_read");

    for (int i = 0; i < 40; i++) begin
      int d, w;
      d = $urandom_range(0, 1);
      w = ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, 4);
      txn(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, w,
          $urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mysystem_pio_master.md
MYSYSTEM_PIO_MASTER -- requirements
Module: mysystem_pio_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2, word address width on the bus.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have parameter RD_LAT, default 0, slave read latency in cycles, legal values 0 or 1.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, maximum waitrequest cycles before abort, range 1..65535.
REQ-005 The block SHALL have ports clk (in, 1, sole clock) and reset (in, 1, asynchronous, active-high).
REQ-006 The block SHALL have ports cmd_valid (in, 1) and cmd_ready (out, 1), the command handshake.
REQ-007 The block SHALL have ports cmd_write (in, 1, 1 = write), cmd_address (in, ADDR_W) and cmd_wdata (in, DATA_W).
REQ-008 The block SHALL have ports rsp_valid (out, 1) and rsp_ready (in, 1), the response handshake.
REQ-009 The block SHALL have ports rsp_rdata (out, DATA_W) and rsp_error (out, 1, timeout flag).
REQ-010 The block SHALL have bus ports avm_address (out, ADDR_W), avm_chipselect (out, 1), avm_write_n (out, 1), avm_read_n (out, 1), avm_writedata (out, DATA_W), avm_readdata (in, DATA_W) and avm_waitrequest (in, 1; tie 0 for zero-wait slaves).

Function
REQ-011 The FSM SHALL have four states: IDLE, ACCESS, RDWAIT and RESP.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-013 On acceptance, command fields SHALL be registered into the avm_* outputs and the FSM SHALL move to ACCESS on the next edge.
REQ-014 In ACCESS, avm_chipselect SHALL be 1, avm_write_n SHALL be 0 for a write, and avm_read_n SHALL be 0 for a read; address and writedata SHALL stay stable.
REQ-015 In ACCESS with avm_waitrequest = 0, the access SHALL complete that cycle, with the bus deasserted next cycle.
REQ-016 On a read with RD_LAT = 0, avm_readdata SHALL be sampled in the completing cycle.
REQ-017 On a read with RD_LAT = 1, the FSM SHALL enter RDWAIT and sample avm_readdata in the RDWAIT cycle.
REQ-018 After completion the FSM SHALL enter RESP and hold rsp_valid = 1 until rsp_ready = 1, then return to IDLE.
REQ-019 rsp_rdata SHALL equal the sampled read data for reads and SHALL be 0 for writes.
REQ-020 A 16-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle in which avm_waitrequest = 1.
REQ-021 When the wait counter reaches TIMEOUT, the bus SHALL deassert and the FSM SHALL enter RESP with rsp_error = 1 and rsp_rdata = 0; rsp_error SHALL be 0 otherwise.
REQ-022 Minimum transaction latency, from the accept edge to rsp_valid, SHALL be 2 cycles for a write or an RD_LAT = 0 read, and 3 cycles for an RD_LAT = 1 read.
REQ-023 Outside ACCESS and RDWAIT, avm_chipselect SHALL be 0 and avm_write_n and avm_read_n SHALL be 1; avm_read_n and avm_write_n SHALL never be 0 together.
REQ-024 rsp_ready = 1 outside RESP SHALL be ignored, and a cmd_valid asserted outside IDLE SHALL not be accepted.
REQ-025 Back-to-back operation: a response accepted in RESP SHALL allow a new command to be accepted in the immediately following IDLE cycle.

Reset
REQ-026 On reset assertion, asynchronously: the FSM SHALL go to IDLE, the wait counter and rsp_rdata SHALL go to 0, rsp_valid and rsp_error SHALL go to 0, avm_chipselect SHALL go to 0, and avm_write_n and avm_read_n SHALL go to 1.
REQ-027 On reset assertion, avm_address and avm_writedata SHALL go to 0.
REQ-028 Reset during ACCESS SHALL abandon the transfer and SHALL produce no response.
REQ-029 cmd_ready SHALL be 1 on the first clk edge after reset deassertion.

Structure
REQ-030 The state encoding and the default widths and timeout SHALL be placed in the shared package mysystem_pio_pkg.
REQ-031 The wait counter SHALL be a sub-module mysystem_wait_timer, with inputs clear and enable and output expired.
REQ-032 No other hierarchy SHALL be used.

Verification
REQ-033 Zero-wait write: cmd write, address 0, data 0x1 with waitrequest = 0 -> one ACCESS cycle with chipselect = 1 and write_n = 0; rsp_valid 2 cycles after accept; rsp_error = 0.
REQ-034 Zero-wait read, RD_LAT = 0: slave readdata = 0x00000001 at address 0 -> rsp_rdata = 0x00000001.
REQ-035 Read with RD_LAT = 1: slave returns 0xA5A5A5A5 one cycle after the read -> rsp_rdata = 0xA5A5A5A5; rsp_valid 3 cycles after accept.
REQ-036 Waitrequest held 3 cycles -> address and write_n stable for 4 ACCESS cycles; completion on the 4th cycle; rsp_error = 0.
REQ-037 Waitrequest stuck at 1 with TIMEOUT = 8 -> bus released after 8 wait cycles; rsp_error = 1; rsp_rdata = 0.
REQ-038 Reset pulse mid-ACCESS, then rsp_ready held 0 in a later RESP -> no response after reset; chipselect = 0 immediately; rsp_valid held until rsp_ready rises; cmd_ready = 0 throughout RESP.
